// File: rtl/tinyalu_pkg.sv
// Shared types for the ALU593 datapath and its command arbiter.
// Holds the opcode encoding, the arbiter state encoding and the nop-class helper.
package tinyalu_pkg;

    typedef enum logic [3:0] {
        op_nop  = 4'h0,
        op_add  = 4'h1,
        op_and  = 4'h2,
        op_xor  = 4'h3,
        op_mul  = 4'h4,
        op_sub  = 4'h5,
        op_or   = 4'h6,
        op_sp0  = 4'h7,
        op_sp1  = 4'h8,
        op_nop1 = 4'h9,
        op_res0 = 4'hA,
        op_res1 = 4'hB,
        op_res2 = 4'hC,
        op_res3 = 4'hD,
        op_res4 = 4'hE,
        op_res5 = 4'hF
    } alu_opcode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // Smallest width the watchdog counter is allowed to shrink to.
    localparam int ARB_TMO_MIN_W = 8;

    // Nop-class opcodes complete without the ALU ever raising done.
    function automatic logic is_nop_op(alu_opcode_t op);
        return (op == op_nop) || (op == op_nop1);
    endfunction

endpackage

// File: rtl/alu593_arbiter_rr_picker.sv
// Combinational round-robin picker: the first valid requester found
// scanning upward from last_grant+1 (wrapping modulo NREQ) wins.
module rr_picker #(
    parameter  int NREQ = 2,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IW-1:0]   last_grant,
    output logic [IW-1:0]   winner,
    output logic            found
);

    logic [IW:0]   sum;
    logic [IW-1:0] idx;

    // Scan from the farthest offset down so the nearest valid requester overwrites the rest.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        sum    = '0;
        idx    = '0;
        for (int off = NREQ; off >= 1; off--) begin
            sum = {1'b0, last_grant} + (IW+1)'(off);
            if (sum >= (IW+1)'(NREQ)) begin
                idx = IW'(sum - (IW+1)'(NREQ));
            end else begin
                idx = IW'(sum);
            end
            if (req_valid[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu593_arbiter.sv
// Round-robin command arbiter/sequencer in front of one ALU593 instance.
// Optional watchdog on the ALU done handshake: define ALU593_ARB_TIMEOUT_EN.
//
//   state | meaning
//   IDLE  | waiting for any req_valid; accepts the round-robin winner
//   RUN   | alu_start held with latched op/A/B until done (or nop, or watchdog)
//   RESP  | one-cycle rsp_valid pulse to the owner, then back to IDLE
module alu593_arbiter
    import tinyalu_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  alu_opcode_t       req_op [NREQ],
    input  logic [7:0]        req_a  [NREQ],
    input  logic [7:0]        req_b  [NREQ],
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [15:0]       rsp_result,
    output logic              rsp_error,
    output logic              rsp_timeout,
    output logic              busy,
    output logic              alu_start,
    output alu_opcode_t       alu_op,
    output logic [7:0]        alu_a,
    output logic [7:0]        alu_b,
    input  logic              alu_done,
    input  logic [15:0]       alu_result,
    input  logic              alu_error
);

    localparam int IW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8) begin : g_nreq_range
        $error("alu593_arbiter: NREQ must be within 2..8");
    end
    if (TIMEOUT < 1) begin : g_timeout_range
        $error("alu593_arbiter: TIMEOUT must be at least 1");
    end

    arb_state_t    state, state_n;
    logic [IW-1:0] last_grant;
    logic [IW-1:0] owner;
    logic [IW-1:0] winner;
    logic          found;
    logic          accept;
    logic          rsp_load;
    logic [15:0]   res_n;
    logic          err_n;

`ifdef ALU593_ARB_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT + 1) > ARB_TMO_MIN_W) ? $clog2(TIMEOUT + 1) : ARB_TMO_MIN_W;
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);

    logic [TW-1:0] tmo_cnt;
    logic          tmo_exp;
    logic          tmo_n;

    assign tmo_exp = (tmo_cnt == '0);
`endif

    rr_picker #(
        .NREQ(NREQ)
    ) u_picker (
        .req_valid (req_valid),
        .last_grant(last_grant),
        .winner    (winner),
        .found     (found)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state, accept pulse and response capture selection.
    always_comb begin
        state_n   = state;
        accept    = 1'b0;
        req_ready = '0;
        rsp_load  = 1'b0;
        res_n     = '0;
        err_n     = 1'b0;
`ifdef ALU593_ARB_TIMEOUT_EN
        tmo_n     = 1'b0;
`endif
        case (state)
            IDLE: begin
                // No accept while reset is held, so nobody sees a ready that gets discarded.
                if (found && !reset) begin
                    accept            = 1'b1;
                    req_ready[winner] = 1'b1;
                    state_n           = RUN;
                end
            end
            RUN: begin
                if (is_nop_op(alu_op)) begin
                    state_n  = RESP;
                    rsp_load = 1'b1;
                end else if (alu_done) begin
                    state_n  = RESP;
                    rsp_load = 1'b1;
                    res_n    = alu_result;
                    err_n    = alu_error;
                end
`ifdef ALU593_ARB_TIMEOUT_EN
                // Checked after done so a done on the expiry cycle still gives a normal response.
                else if (tmo_exp) begin
                    state_n  = RESP;
                    rsp_load = 1'b1;
                    err_n    = 1'b1;
                    tmo_n    = 1'b1;
                end
`endif
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Grant bookkeeping, registered ALU drive and held response data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= IW'(NREQ - 1);
            owner      <= '0;
            alu_start  <= 1'b0;
            alu_op     <= op_nop;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_result <= '0;
            rsp_error  <= 1'b0;
        end else begin
            alu_start <= (state_n == RUN);
            if (accept) begin
                last_grant <= winner;
                owner      <= winner;
                alu_op     <= req_op[winner];
                alu_a      <= req_a[winner];
                alu_b      <= req_b[winner];
            end
            if (rsp_load) begin
                rsp_result <= res_n;
                rsp_error  <= err_n;
            end
        end
    end

`ifdef ALU593_ARB_TIMEOUT_EN
    // Watchdog down-counter, reloaded on every accept; terminal count is zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (accept) begin
            tmo_cnt <= TMO_LOAD;
        end else if (state == RUN && !tmo_exp) begin
            tmo_cnt <= tmo_cnt - 1'b1;
        end
    end

    // Timeout flag is held alongside the rest of the response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_timeout <= 1'b0;
        end else if (rsp_load) begin
            rsp_timeout <= tmo_n;
        end
    end
`else
    assign rsp_timeout = 1'b0;
`endif

    // Response strobe goes only to the owner of the finished command.
    always_comb begin
        rsp_valid = '0;
        if (state == RESP) begin
            rsp_valid[owner] = 1'b1;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: doc/alu593_arbiter.md
# alu593_arbiter

Round-robin arbiter and sequencer that shares one ALU593 datapath between `NREQ` independent command requesters. It accepts one command at a time with a valid/ready handshake and drives the ALU's `start`/`op`/`A`/`B` inputs. It holds `start` until the ALU completes, then returns the captured result and error flag to the requester that owns the command. It sits between the command sources (sequencers, test harness) and the ALU593 instance.

## Interface
- `NREQ`, 2, number of requesters (2..8)
- `TIMEOUT`, 32, max cycles waiting for `alu_done` (used only with the timeout feature)

- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `req_valid`  in  NREQ  requester i presents a command
- `req_op`  in  NREQ×4  per-requester opcode, type `alu_opcode_t`
- `req_a`, `req_b`  in  NREQ×8 each  per-requester operands
- `req_ready`  out  NREQ  one-hot, 1-cycle accept pulse
- `rsp_valid`  out  NREQ  one-hot, 1-cycle response pulse to the owner
- `rsp_result`  out  16  result for the owner's command
- `rsp_error`  out  1  ALU error flag (reserved opcode) or timeout
- `rsp_timeout`  out  1  response was produced by the watchdog
- `busy`  out  1  a command is in flight (state ≠ IDLE)
- `alu_start`, `alu_op`(4), `alu_a`(8), `alu_b`(8)  out  ALU drive, all registered
- `alu_done`  in  1, `alu_result`  in  16, `alu_error`  in  1  ALU completion

## Operation
- States: `IDLE`, `RUN`, `RESP`.
- **IDLE:**
  - If any `req_valid` is high, pick the winner by round-robin. Priority starts at `last_grant+1` mod `NREQ`.
  - Pulse `req_ready[winner]` and latch op, A, B and the owner index. Update `last_grant`, then go to `RUN`.
- **RUN:**
  - `alu_start`=1 and the latched op/A/B are driven, stable.
  - Nop class (`op_nop`, `op_nop1`): hold `start` exactly 1 cycle, result=0, error=0, go to `RESP`. `alu_done` is not awaited.
  - Other opcodes: wait for `alu_done`=1. Capture `alu_result` and `alu_error`, then go to `RESP`.
  - Reserved opcodes are forwarded unchanged. The ALU's `error` is passed through as `rsp_error`.
- **RESP:**
  - `alu_start`=0 and `rsp_valid[owner]`=1 for one cycle, with `rsp_result`/`rsp_error` valid.
  - Go to `IDLE`.
- Handshake rules:
  - A requester holds `req_valid`, `req_op`, `req_a` and `req_b` stable until `req_ready`.
  - Dropping `req_valid` before `req_ready` withdraws the request with no side effect.
- `rsp_result`, `rsp_error` and `rsp_timeout` hold their value until the next response.
- Requests with `req_valid`=0 never win.
- With a single active requester, that requester wins every time.
- `alu_done` is sampled only in `RUN`. Done pulses arriving in `IDLE` or `RESP` are ignored.

## Timing
- Reset (async, immediate): state `IDLE` and `last_grant`=`NREQ-1`, so requester 0 has first priority. All outputs are 0. An in-flight command is discarded with no response.
- Command accepted at cycle N (`req_ready` high): `alu_start` rises at N+1.
- `alu_done` sampled high at cycle M: `alu_start` falls and `rsp_valid` rises at M+1. The next accept can occur at M+2.
- Nop command accepted at N: `start` is high at N+1 only, and `rsp_valid` is high at N+2.
- Throughput is at most one command per 3 cycles.
- A new `req_valid` arriving during `RUN` or `RESP` waits and is arbitrated in the next `IDLE`.

## Configuration
- Macro: `ALU593_ARB_TIMEOUT_EN`.
- **Defined:**
  - An 8-bit-minimum counter runs in `RUN` for non-nop ops.
  - After `TIMEOUT` cycles without `alu_done`: drop `start`, go to `RESP` with result=0, `rsp_error`=1, `rsp_timeout`=1.
  - A `alu_done` arriving on the same cycle the counter expires wins: normal response, `rsp_timeout`=0.
- **Undefined:** no counter. `RUN` waits indefinitely and `rsp_timeout` is tied to 0.

## Structure
- Shared package `tinyalu_pkg`:
  - Existing `alu_opcode_t`.
  - New `arb_state_t` (`IDLE`/`RUN`/`RESP`).
  - Function `is_nop_op(alu_opcode_t)`.
- Sub-module `rr_picker`: combinational round-robin winner from `req_valid` and `last_grant`, with a `found` output. Parameterized by `NREQ`.

## Test plan
- Req0 only, op_add, A=8'h12, B=8'h34, ALU model done after 1 cycle -> `req_ready`=01, `rsp_valid`=01, `rsp_result`=16'h0046, `rsp_error`=0.
- Both requesters hold valid for 4 commands (op_mul, A=8'hFF, B=8'hFF) -> grants alternate 0,1,0,1 and each `rsp_result`=16'hFE01 goes to the correct owner.
- Req1 op_nop -> `alu_start` high exactly 1 cycle, `rsp_valid`=10 two cycles after accept, result 0.
- Reserved op_res1 with ALU asserting error -> `rsp_error`=1 to the owner, and the next request is served normally.
- ALU never asserts done, `ALU593_ARB_TIMEOUT_EN` defined, `TIMEOUT`=32 -> `rsp_timeout`=1, `rsp_error`=1, `rsp_result`=0 after 32 `RUN` cycles. Undefined: `busy` stays 1 indefinitely.
- `reset` asserted mid-`RUN` of op_sp0 -> `alu_start` and `busy` fall immediately, no `rsp_valid`, and requester 0 wins first after release.
